// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch sequencer for a small accumulator core. Drives the address
// of a synchronous instruction memory, tracks which address the returned word
// belongs to, and handles stall, jump redirect and end-of-program halt.
//
// Optional feature macro: IFETCH_PERF_CNT_EN adds the fetch_cnt output, a
// saturating count of cycles in which a live instruction was accepted.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        pulse: begin fetching at address 0 (ignored while fetching)
//   stall        hold the fetch stream, current instruction stays on instr_out
//   br_taken     one-cycle redirect from execute
//   br_target    redirect destination
//   imem_addr    instruction memory address (combinational)
//   imem_data    memory read data, one cycle after imem_addr
//   instr_out    current instruction word
//   instr_valid  instr_out is a live instruction
//   pc_out       address of the word on instr_out
//   busy         fetching
//   done         sticky end-of-program flag, cleared by start
//   fetch_cnt    (IFETCH_PERF_CNT_EN only) accepted-instruction cycle count
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
   parameter int         ADDR_W     = 12,
   parameter int         INSTR_W    = 17,
   parameter logic [4:0] ENDOP_CODE = 5'd31
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               busy,
   output logic               done
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [15:0]        fetch_cnt
`endif
);

   // state | meaning
   // IDLE  | after reset, waiting for start
   // FETCH | streaming instructions from memory
   // HALT  | end opcode seen, waiting for start
   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               req_vld_q, req_vld_d;
   logic               done_q, done_d;
   logic               endop_hit;
   logic               start_acc;

   assign start_acc = start && (state_q != FETCH);

   // Only a live word that is actually being consumed can halt the stream.
   assign endop_hit = req_vld_q && !stall &&
                      (imem_data[INSTR_W-1 -: 5] == ENDOP_CODE);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      req_vld_d = req_vld_q;
      done_d    = done_q;
      imem_addr = '0;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d = FETCH;
               pc_d    = '0;
               done_d  = 1'b0;
            end
         end
         FETCH: begin
            if (br_taken) begin
               // Squash the word already in flight; redirect wins over stall.
               imem_addr = pc_q;
               pc_d      = br_target;
               req_vld_d = 1'b0;
            end else if (endop_hit) begin
               // The word issued this cycle is discarded.
               imem_addr = pc_q;
               state_d   = HALT;
               done_d    = 1'b1;
               req_vld_d = 1'b0;
            end else if (stall) begin
               // Re-read the held address so instr_out stays stable.
               imem_addr = req_pc_q;
            end else begin
               imem_addr = pc_q;
               pc_d      = pc_q + ADDR_W'(1);
               req_pc_d  = pc_q;
               req_vld_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         req_pc_q  <= '0;
         req_vld_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         req_vld_q <= req_vld_d;
         done_q    <= done_d;
      end
   end

   assign instr_out   = imem_data;
   assign instr_valid = req_vld_q;
   assign pc_out      = req_pc_q;
   assign busy        = (state_q == FETCH);
   assign done        = done_q;

`ifdef IFETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
      end else if (start_acc) begin
         fetch_cnt_q <= '0;
      end else if (req_vld_q && !stall && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Self-checking bench for instr_fetch_ctrl. A table of per-cycle vectors covers
// reset, start handling and the halt program; hand sequences cover stall,
// redirect, redirect+stall, mid-fetch reset, pc wrap and a 99-word program.
// A scoreboard queue holds the expected {pc, word} of every instruction the
// datapath should consume; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        br_taken;
   logic [11:0] br_target;
   logic [11:0] imem_addr;
   logic [16:0] imem_data;
   logic [16:0] instr_out;
   logic        instr_valid;
   logic [11:0] pc_out;
   logic        busy;
   logic        done;
`ifdef IFETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt;
`endif

   instr_fetch_ctrl #(.ADDR_W(12), .INSTR_W(17), .ENDOP_CODE(5'd31)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .busy        (busy),
      .done        (done)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous instruction memory
   logic [16:0] mem [0:4095];
   always @(posedge clk) imem_data <= mem[imem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // scoreboard
   typedef struct {
      logic [11:0] pc;
      logic [16:0] instr;
   } sb_t;
   sb_t sbq[$];

   task automatic push_range(input int lo, input int n);
      sb_t e;
      for (int i = 0; i < n; i++) begin
         int a;
         a       = (lo + i) % 4096;
         e.pc    = 12'(a);
         e.instr = mem[a];
         sbq.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      #3;
      if (rst_n && instr_valid && !stall && !br_taken) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_extra: got pc %0d expected no instruction", pc_out);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_pc", int'(pc_out), int'(e.pc));
            chk("sb_instr", int'(instr_out), int'(e.instr));
         end
      end
   end

   // per-cycle vector table
   typedef struct {
      logic        start;
      logic        stall;
      logic        br;
      logic [11:0] tgt;
      logic [11:0] e_addr;
      logic        e_valid;
      logic [11:0] e_pc;
      logic        e_busy;
      logic        e_done;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int s, input int st, input int b, input int t,
                      input int ea, input int ev, input int ep, input int eb,
                      input int ed);
      vec_t v;
      v.start   = 1'(s);
      v.stall   = 1'(st);
      v.br      = 1'(b);
      v.tgt     = 12'(t);
      v.e_addr  = 12'(ea);
      v.e_valid = 1'(ev);
      v.e_pc    = 12'(ep);
      v.e_busy  = 1'(eb);
      v.e_done  = 1'(ed);
      tbl.push_back(v);
   endtask

   task automatic wait_pc(input int target, input string nm);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk); #1;
         if (instr_valid && pc_out == 12'(target)) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s: pc_out %0d never reached, last %0d", nm, target, pc_out);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {5'd0, 12'(i)};
      mem[0] = {5'd1, 12'd0};      // clac
      mem[1] = {5'd2, 12'd0};      // mvacr1
      mem[2] = {5'd3, 12'd4094};   // ldiac 4094
      mem[3] = {5'd31, 12'd0};     // endop

      //  st st br tgt  addr v pc busy done
      add(0, 0, 0, 0,    0, 0, 0, 0, 0);
      add(0, 0, 1, 5,    0, 0, 0, 0, 0);   // redirect in IDLE ignored
      add(1, 0, 0, 0,    0, 0, 0, 0, 0);
      add(0, 0, 0, 0,    0, 0, 0, 1, 0);
      add(0, 0, 0, 0,    1, 1, 0, 1, 0);
      add(1, 0, 0, 0,    2, 1, 1, 1, 0);   // start while fetching ignored
      add(0, 0, 0, 0,    3, 1, 2, 1, 0);
      add(0, 0, 0, 0,    4, 1, 3, 1, 0);   // endop on instr_out
      add(0, 0, 0, 0,    0, 0, 3, 0, 1);
      add(0, 0, 1, 9,    0, 0, 3, 0, 1);   // redirect in HALT ignored
      add(0, 0, 0, 0,    0, 0, 3, 0, 1);
      add(1, 0, 0, 0,    0, 0, 3, 0, 1);
      add(0, 0, 0, 0,    0, 0, 3, 1, 0);
      add(0, 0, 0, 0,    1, 1, 0, 1, 0);
      add(0, 0, 0, 0,    2, 1, 1, 1, 0);
      add(0, 0, 0, 0,    3, 1, 2, 1, 0);
      add(0, 0, 0, 0,    4, 1, 3, 1, 0);
      add(0, 0, 0, 0,    0, 0, 3, 0, 1);

      rst_n = 1'b0; start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      push_range(0, 4);
      push_range(0, 4);
      foreach (tbl[i]) begin
         @(negedge clk); #1;
         start = tbl[i].start; stall = tbl[i].stall;
         br_taken = tbl[i].br; br_target = tbl[i].tgt;
         #1;
         chk($sformatf("v%0d_addr", i), int'(imem_addr), int'(tbl[i].e_addr));
         chk($sformatf("v%0d_valid", i), int'(instr_valid), int'(tbl[i].e_valid));
         chk($sformatf("v%0d_pc", i), int'(pc_out), int'(tbl[i].e_pc));
         chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
         chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].e_done));
      end
      chk("prog_sb_empty", sbq.size(), 0);

      // long stream: stall at 5, redirect at 47, redirect+stall at 78
      mem[3] = {5'd0, 12'd3};
      push_range(0, 47);
      pulse_start();
      wait_pc(5, "wait_pc5");
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_addr", int'(imem_addr), 5);
         chk("stall_pc", int'(pc_out), 5);
         chk("stall_valid", int'(instr_valid), 1);
         chk("stall_instr", int'(instr_out), int'(mem[5]));
         @(negedge clk); #1;
      end
      stall = 1'b0;
      #1 chk("stall_rel_pc", int'(pc_out), 5);
      @(negedge clk); #2;
      chk("resume_pc", int'(pc_out), 6);
      chk("resume_valid", int'(instr_valid), 1);

      wait_pc(47, "wait_pc47");
      br_taken = 1'b1; br_target = 12'd2;
      push_range(2, 76);
      @(negedge clk); #1 br_taken = 1'b0;
      #1 chk("br_squash_valid", int'(instr_valid), 0);
      @(negedge clk); #2;
      chk("br_pc", int'(pc_out), 2);
      chk("br_valid", int'(instr_valid), 1);

      wait_pc(78, "wait_pc78");
      br_taken = 1'b1; stall = 1'b1; br_target = 12'd2;
      push_range(2, 28);
      @(negedge clk); #1 br_taken = 1'b0; stall = 1'b0;
      #1 chk("brst_squash_valid", int'(instr_valid), 0);
      @(negedge clk); #2;
      chk("brst_pc", int'(pc_out), 2);
      chk("brst_valid", int'(instr_valid), 1);

      // asynchronous reset mid-fetch
      wait_pc(30, "wait_pc30");
      rst_n = 1'b0;
      #1;
      chk("rst_addr", int'(imem_addr), 0);
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_pc", int'(pc_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_fetch_cnt", int'(fetch_cnt), 0);
`endif
      chk("stream_sb_empty", sbq.size(), 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // restart from 0, then jump near the top of memory and wrap
      push_range(0, 3);
      pulse_start();
      wait_pc(3, "restart_pc3");
      br_taken = 1'b1; br_target = 12'd4093;
      push_range(4093, 5);
      @(negedge clk); #1 br_taken = 1'b0;
      wait_pc(1, "wrap_pc1");
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      chk("wrap_sb_empty", sbq.size(), 0);

      // 99-instruction straight-line program
      mem[98] = {5'd31, 12'd0};
      push_range(0, 99);
      pulse_start();
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
         end
         chk("p99_done_seen", int'(seen), 1);
      end
      #1;
      chk("p99_busy", int'(busy), 0);
      chk("p99_addr", int'(imem_addr), 0);
      chk("p99_valid", int'(instr_valid), 0);
`ifdef IFETCH_PERF_CNT_EN
      chk("p99_fetch_cnt", int'(fetch_cnt), 99);
`endif
      chk("p99_sb_empty", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
